// File: rtl/avs_crc_pkg.sv
// Shared definitions for the multi-channel Avalon-MM CRC accelerator:
// register map, STATUS identifier, FSM states and the reflected byte step.
package avs_crc_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_RESULT = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam logic [15:0] STATUS_ID = 16'hC32A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One byte of a reflected CRC, evaluated at 'width' bits inside a 32-bit container.
  function automatic logic [31:0] crc_byte_step(
    input logic [31:0] acc,
    input logic [7:0]  data_byte,
    input logic [31:0] poly,
    input int          width
  );
    logic [31:0] mask;
    logic [31:0] a;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    a = (acc ^ {24'd0, data_byte}) & mask;
    for (int i = 0; i < 8; i++) begin
      a = a[0] ? ((a >> 1) ^ (poly & mask)) : (a >> 1);
    end
    return a & mask;
  endfunction

endpackage

// File: rtl/avs_crc_byte_unit.sv
// Combinational single-byte CRC step; one instance is shared by all channels.
module avs_crc_byte_unit
  import avs_crc_pkg::*;
#(
  parameter int          CRC_W = 32,
  parameter logic [31:0] POLY  = 32'hEDB88320
) (
  input  logic [CRC_W-1:0] acc_in,
  input  logic [7:0]       data_in,
  output logic [CRC_W-1:0] acc_out
);

  logic [31:0] acc_ext;
  logic [31:0] step_ext;

  assign acc_ext  = 32'(acc_in);
  assign step_ext = crc_byte_step(acc_ext, data_in, POLY, CRC_W);
  assign acc_out  = step_ext[CRC_W-1:0];

endmodule

// File: rtl/avs_mm_crc_multi.sv
// Multi-channel Avalon-MM CRC slave: one byte per clock through a shared step unit,
// stalling DATA writes with waitrequest until all four lanes have been visited.
module avs_mm_crc_multi
  import avs_crc_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CRC_W    = 32,
  parameter logic [31:0] POLY_REV = 32'hEDB88320,
  parameter logic [31:0] INIT     = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT  = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic        avs_waitrequest
);

  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_W  = XOR_OUT[CRC_W-1:0];

  logic [5:0]          ch;
  logic [1:0]          offset;
  logic [CH_IDX_W-1:0] ch_idx;
  logic                valid_ch;
  logic                data_wr;
  logic                ctrl_clr;

  state_t              state_reg, state_next;
  logic [1:0]          idx_reg, idx_next;
  logic                load;
  logic [31:0]         data_reg;
  logic [3:0]          be_reg;
  logic [CH_IDX_W-1:0] ch_reg;

  logic [NUM_CH*CRC_W-1:0] acc_flat;
  logic [CRC_W-1:0]        step_in;
  logic [CRC_W-1:0]        step_out;
  logic [7:0]              step_byte;
  logic                    step_en;
  logic [CRC_W-1:0]        acc_sel;
  logic [31:0]             rd_mux;
  logic                    busy;

  assign ch       = avs_address[7:2];
  assign offset   = avs_address[1:0];
  assign ch_idx   = ch[CH_IDX_W-1:0];
  assign valid_ch = ({26'd0, ch} < 32'(NUM_CH));
  assign data_wr  = avs_write && (offset == OFF_DATA) && valid_ch;
  assign ctrl_clr = avs_write && (offset == OFF_CTRL) && valid_ch && avs_writedata[0];
  assign busy     = (state_reg != IDLE);

  assign avs_waitrequest = reset || (data_wr && (state_reg != DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      data_reg  <= 32'd0;
      be_reg    <= 4'd0;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (load) begin
        data_reg <= avs_writedata;
        be_reg   <= avs_byteenable;
        ch_reg   <= ch_idx;
      end
    end
  end

  // The request is captured in IDLE, so the master's bus values are irrelevant while BUSY.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (data_wr) begin
          load       = 1'b1;
          idx_next   = 2'd0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        idx_next = idx_reg + 2'd1;
        if (idx_reg == 2'd3) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign step_en   = (state_reg == BUSY) && be_reg[idx_reg];
  assign step_byte = data_reg[{idx_reg, 3'b000} +: 8];
  assign step_in   = acc_flat[int'(ch_reg)*CRC_W +: CRC_W];

  avs_crc_byte_unit #(
    .CRC_W (CRC_W),
    .POLY  (POLY_REV)
  ) u_byte_unit (
    .acc_in  (step_in),
    .data_in (step_byte),
    .acc_out (step_out)
  );

  // A clear landing on the channel being stepped wins over the step.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CRC_W-1:0] acc_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_reg <= INIT_W;
      end else if (ctrl_clr && (ch_idx == CH_IDX_W'(gi))) begin
        acc_reg <= INIT_W;
      end else if (step_en && (ch_reg == CH_IDX_W'(gi))) begin
        acc_reg <= step_out;
      end
    end

    assign acc_flat[gi*CRC_W +: CRC_W] = acc_reg;
  end

  assign acc_sel = acc_flat[int'(ch_idx)*CRC_W +: CRC_W];

  always_comb begin
    rd_mux = 32'd0;
    case (offset)
      OFF_RESULT: if (valid_ch) rd_mux = 32'(acc_sel ^ XOR_W);
      OFF_STATUS: rd_mux = {STATUS_ID, 8'(NUM_CH), 6'(CRC_W), 1'b0, busy};
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= 32'd0;
    end else if (avs_read && !avs_write) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule
